// File: rtl/cam_pkg.sv
// Shared types and defaults for the camera pixel packer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: default frame geometry, packer state encoding, the 35-bit
// word-plus-sideband layout, and a helper that zero-pads a partial word.
package cam_pkg;

    localparam int PIX_PER_LINE_DEF = 640;
    localparam int NUM_LINES_DEF    = 480;
    localparam int FIFO_DEPTH_DEF   = 16;

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        ACTIVE     = 2'd1,
        DROP       = 2'd2
    } cam_state_t;

    // {eof, eol, sof, data[31:0]}; byte 0 of the group sits in data[7:0].
    typedef struct packed {
        logic        eof;
        logic        eol;
        logic        sof;
        logic [31:0] data;
    } cam_word_t;

    localparam int WORD_W = $bits(cam_word_t);

    // Builds a short word from the bytes already held; lanes at or above
    // num_bytes are forced to zero so stale bytes from earlier groups never leak.
    function automatic logic [31:0] pad_partial(input logic [23:0] held,
                                                input logic [1:0]  num_bytes);
        logic [31:0] w;
        w = '0;
        case (num_bytes)
            2'd1:    w = {24'h0, held[7:0]};
            2'd2:    w = {16'h0, held[15:0]};
            2'd3:    w = {8'h0,  held[23:0]};
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/cam_pixel_packer_if.sv
// Packed-word stream from the pixel packer to the frame-buffer writer.
// Latency: n/a (wires only).
// Backpressure: out_ready from the slave holds the head word in place.
//
// Signals: out_data/out_sof/out_eol/out_eof word and markers, out_valid head
// valid, out_ready consumer accept. master = packer, slave = consumer.
interface cam_pixel_packer_if;

    logic [31:0] out_data;
    logic        out_sof;
    logic        out_eol;
    logic        out_eof;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output out_data,
        output out_sof,
        output out_eol,
        output out_eof,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_sof,
        input  out_eol,
        input  out_eof,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/cam_word_fifo.sv
// Synchronous show-ahead FIFO for packed camera words.
// Latency: a pushed word is visible at the head one clock after the push.
// Backpressure: push is ignored when full unless a pop happens the same cycle.
//
// Ports: clk, rst_n (sync, active-low), push/push_dat in, pop in,
// head_dat (current head, valid when !empty), full, empty, count.
module cam_word_fifo
    import cam_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra MSB so full and empty differ only in that bit.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign head_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/cam_pixel_packer.sv
// Packs the 8-bit camera pixel stream into 32-bit words tagged sof/eol/eof.
// Latency: out_valid rises one pclk after the byte completing a word is sampled.
// Backpressure: FIFO_DEPTH-word buffer; on overflow the rest of the frame is dropped.
//
// Ports: pclk, rst_n (sync, active-low); vsync, pixel_valid, pixel[7:0] from
// the receiver; out_if (master) word stream; overflow (sticky), drop_cnt
// (saturating), frame_cnt (vsync rising edges, wraps).
module cam_pixel_packer
    import cam_pkg::*;
#(
    parameter int PIX_PER_LINE = PIX_PER_LINE_DEF,
    parameter int NUM_LINES    = NUM_LINES_DEF,
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
    input  logic                      pclk,
    input  logic                      rst_n,
    input  logic                      vsync,
    input  logic                      pixel_valid,
    input  logic [7:0]                pixel,
    cam_pixel_packer_if.master        out_if,
    output logic                      overflow,
    output logic [15:0]               drop_cnt,
    output logic [15:0]               frame_cnt
);

    localparam int PC_W  = $clog2(PIX_PER_LINE + 1);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [PC_W-1:0]  LAST_PIX  = PC_W'(PIX_PER_LINE - 1);
    localparam logic [15:0]      LAST_LINE = 16'(NUM_LINES - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    cam_state_t        state_q;
    cam_state_t        state_d;

    logic              vsync_p1;
    logic              pixel_valid_p1;
    logic [1:0]        byte_idx;
    logic [23:0]       held;
    logic [PC_W-1:0]   pix_cnt;
    logic [15:0]       line_cnt;
    logic              sof_pending;

    logic              vs_rise;
    logic              line_end;
    logic              packing;
    logic              byte_take;
    logic              full_word;
    logic              part_word;
    logic              push_req;
    logic              push_ok;
    logic              pop;
    logic              fifo_push;
    logic              word_drop;
    cam_word_t         new_word;

    cam_word_t         fifo_head;
    cam_word_t         head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    // ------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------
    assign vs_rise  = vsync && !vsync_p1;
    assign line_end = pixel_valid_p1 && !pixel_valid;

    // The packer also runs in DROP so that every word formed there can be
    // counted as dropped. A frame boundary overrides the byte on that edge.
    assign packing   = (state_q != WAIT_FRAME) && !vs_rise;
    assign byte_take = packing && pixel_valid;
    assign full_word = byte_take && (byte_idx == 2'd3);
    assign part_word = packing && line_end && (byte_idx != 2'd0);
    assign push_req  = full_word || part_word;

    assign pop     = out_if.out_valid && out_if.out_ready;
    assign push_ok = (fifo_count < DEPTH_CNT) || pop;

    always_comb begin
        new_word     = '0;
        new_word.sof = sof_pending;
        if (full_word) begin
            new_word.data = {pixel, held};
            new_word.eol  = (pix_cnt == LAST_PIX);
        end else begin
            new_word.data = pad_partial(held, byte_idx);
            new_word.eol  = 1'b1;
        end
        new_word.eof = new_word.eol && (line_cnt == LAST_LINE);
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (!rst_n) state_q <= WAIT_FRAME;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (vs_rise) begin
            state_d = ACTIVE;
        end else if (state_q == ACTIVE && push_req && fifo_full && !pop) begin
            state_d = DROP;
        end
    end

    // FSM: outputs
    always_comb begin
        fifo_push = 1'b0;
        word_drop = 1'b0;
        case (state_q)
            ACTIVE: begin
                fifo_push = push_req && push_ok;
                word_drop = push_req && !push_ok;
            end
            DROP: begin
                word_drop = push_req;
            end
            default: begin
                fifo_push = 1'b0;
                word_drop = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Packing datapath and status counters
    // ------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            vsync_p1       <= 1'b0;
            pixel_valid_p1 <= 1'b0;
            byte_idx       <= 2'd0;
            held           <= '0;
            pix_cnt        <= '0;
            line_cnt       <= '0;
            sof_pending    <= 1'b0;
            overflow       <= 1'b0;
            drop_cnt       <= '0;
            frame_cnt      <= '0;
        end else begin
            vsync_p1       <= vsync;
            pixel_valid_p1 <= pixel_valid;

            if (vs_rise) begin
                frame_cnt   <= frame_cnt + 16'd1;
                byte_idx    <= 2'd0;
                pix_cnt     <= '0;
                line_cnt    <= '0;
                sof_pending <= 1'b1;
            end else if (packing) begin
                if (byte_take) begin
                    case (byte_idx)
                        2'd0:    held[7:0]   <= pixel;
                        2'd1:    held[15:8]  <= pixel;
                        2'd2:    held[23:16] <= pixel;
                        default: held        <= held;
                    endcase
                    byte_idx <= byte_idx + 2'd1;
                    // Restart at the nominal line length so an over-long
                    // line gets another eol each PIX_PER_LINE bytes.
                    pix_cnt  <= (pix_cnt == LAST_PIX) ? '0 : pix_cnt + PC_W'(1);
                end else if (line_end) begin
                    byte_idx <= 2'd0;
                    pix_cnt  <= '0;
                    if (line_cnt != 16'hFFFF) line_cnt <= line_cnt + 16'd1;
                end
                if (push_req) sof_pending <= 1'b0;
            end

            if (word_drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output buffer
    // ------------------------------------------------------------------
    cam_word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (pclk),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .push_dat (new_word),
        .pop      (pop),
        .head_dat (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Gate the head so the word bus reads zero whenever nothing is valid.
    assign head = fifo_empty ? '0 : fifo_head;

    assign out_if.out_valid = !fifo_empty;
    assign out_if.out_data  = head.data;
    assign out_if.out_sof   = head.sof;
    assign out_if.out_eol   = head.eol;
    assign out_if.out_eof   = head.eof;

endmodule

// File: tb/tb_cam_pixel_packer.sv
// Bench for cam_pixel_packer: directed scenarios plus random traffic against a queue model.
// Latency: checks sampled on the falling edge after each rising edge.
// Backpressure: out_ready driven per cycle, including long stalls to force overflow.
module tb_cam_pixel_packer;
    import cam_pkg::*;

    localparam int PPL   = 8;
    localparam int NL    = 2;
    localparam int DEPTH = 4;

    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vsync = 1'b0;
    logic        pixel_valid = 1'b0;
    logic [7:0]  pixel = 8'h00;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic [15:0] frame_cnt;

    cam_pixel_packer_if bus();

    cam_pixel_packer #(
        .PIX_PER_LINE (PPL),
        .NUM_LINES    (NL),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .pclk        (pclk),
        .rst_n       (rst_n),
        .vsync       (vsync),
        .pixel_valid (pixel_valid),
        .pixel       (pixel),
        .out_if      (bus),
        .overflow    (overflow),
        .drop_cnt    (drop_cnt),
        .frame_cnt   (frame_cnt)
    );

    always #5 pclk = ~pclk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [34:0] m_q[$];
    logic [7:0]  m_part[$];
    bit          m_vs_p1, m_pv_p1, m_in_frame, m_dropping, m_sof_pend, m_ovf;
    int          m_line_pos, m_line_idx;
    logic [15:0] m_drop, m_frames;

    task automatic model_reset();
        m_q.delete();
        m_part.delete();
        m_vs_p1 = 0; m_pv_p1 = 0; m_in_frame = 0; m_dropping = 0;
        m_sof_pend = 0; m_ovf = 0; m_line_pos = 0; m_line_idx = 0;
        m_drop = 0; m_frames = 0;
    endtask

    task automatic model_step(input bit r, input bit v, input bit p,
                              input logic [7:0] px, input bit rdy);
        bit          pop, have, vsr, fall, eol;
        logic [31:0] data;
        logic [34:0] w;
        if (!r) begin
            model_reset();
            return;
        end
        pop  = rdy && (m_q.size() > 0);
        have = 0;
        eol  = 0;
        w    = '0;
        vsr  = v && !m_vs_p1;
        fall = m_pv_p1 && !p;
        if (vsr) begin
            m_frames   = m_frames + 16'd1;
            m_in_frame = 1; m_dropping = 0; m_sof_pend = 1;
            m_part.delete(); m_line_pos = 0; m_line_idx = 0;
        end else if (m_in_frame) begin
            if (p) begin
                m_part.push_back(px);
                m_line_pos++;
                if (m_part.size() == 4) begin
                    eol = (m_line_pos == PPL);
                    if (eol) m_line_pos = 0;
                    have = 1;
                end
            end else if (fall) begin
                if (m_part.size() > 0) begin
                    eol = 1;
                    have = 1;
                end
                m_line_pos = 0;
            end
            if (have) begin
                data = '0;
                for (int i = 0; i < m_part.size(); i++) data[8*i +: 8] = m_part[i];
                w = {eol && (m_line_idx == NL - 1), eol, m_sof_pend, data};
                m_sof_pend = 0;
                m_part.delete();
            end
            if (!p && fall) m_line_idx++;
        end
        if (pop) void'(m_q.pop_front());
        if (have) begin
            if (m_dropping || m_q.size() >= DEPTH) begin
                if (!m_dropping) begin m_ovf = 1; m_dropping = 1; end
                if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
            end else begin
                m_q.push_back(w);
            end
        end
        m_vs_p1 = v;
        m_pv_p1 = p;
    endtask

    task automatic compare_all();
        check("out_valid", bus.out_valid, m_q.size() > 0);
        if (m_q.size() > 0)
            check("out_word", {bus.out_eof, bus.out_eol, bus.out_sof, bus.out_data}, m_q[0]);
        check("overflow", overflow, m_ovf);
        check("drop_cnt", drop_cnt, m_drop);
        check("frame_cnt", frame_cnt, m_frames);
    endtask

    // One pclk: drive at the falling edge, step the model, check at the next falling edge.
    task automatic cyc(input bit r, input bit v, input bit p, input logic [7:0] px, input bit rdy);
        rst_n = r; vsync = v; pixel_valid = p; pixel = px; bus.out_ready = rdy;
        model_step(r, v, p, px, rdy);
        @(posedge pclk);
        @(negedge pclk);
        compare_all();
    endtask

    task automatic vs_pulse(input bit rdy);
        cyc(1, 1, 0, 8'h00, rdy);
        cyc(1, 1, 0, 8'h00, rdy);
        cyc(1, 0, 0, 8'h00, rdy);
    endtask

    task automatic send_bytes(input logic [7:0] first, input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(1, 0, 1, first + 8'(i), rdy);
    endtask

    // Expected head: flags are {eof, eol, sof}.
    task automatic chk_head(input string tag, input logic [2:0] flags, input logic [31:0] data);
        check(tag, {bus.out_valid, bus.out_eof, bus.out_eol, bus.out_sof, bus.out_data},
              {1'b1, flags, data});
    endtask

    logic [31:0] exp_dat[4];
    logic [2:0]  exp_flg[4];

    initial begin
        int burst, gap;
        bit rv, rp, rr, rrst;
        model_reset();
        bus.out_ready = 1'b0;
        @(negedge pclk);

        // Reset state
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 8'h00, 0);
        check("rst_outs", {bus.out_valid, bus.out_sof, bus.out_eol, bus.out_eof, bus.out_data}, 64'd0);
        check("rst_stat", {overflow, drop_cnt, frame_cnt}, 64'd0);

        // Single line, out_valid one cycle after bytes 04 and 08
        vs_pulse(1);
        send_bytes(8'h01, 3, 1);
        check("s1_pre", bus.out_valid, 1'b0);
        cyc(1, 0, 1, 8'h04, 1);
        chk_head("s1_w0", 3'b001, 32'h04030201);
        send_bytes(8'h05, 3, 1);
        check("s1_mid", bus.out_valid, 1'b0);
        cyc(1, 0, 1, 8'h08, 1);
        chk_head("s1_w1", 3'b010, 32'h08070605);
        cyc(1, 0, 0, 8'h00, 1);
        check("s1_end", bus.out_valid, 1'b0);

        // Partial line
        vs_pulse(1);
        send_bytes(8'hAA, 4, 1);
        chk_head("s2_w0", 3'b001, 32'hADACABAA);
        send_bytes(8'hAE, 2, 1);
        cyc(1, 0, 0, 8'h00, 1);
        chk_head("s2_w1", 3'b010, 32'h0000AFAE);
        cyc(1, 0, 0, 8'h00, 1);

        // Full frame of two lines held in a just-full FIFO
        vs_pulse(0);
        send_bytes(8'h10, 8, 0);
        cyc(1, 0, 0, 8'h00, 0);
        send_bytes(8'h20, 8, 0);
        cyc(1, 0, 0, 8'h00, 0);
        check("s3_frames", frame_cnt, 16'd3);
        check("s3_ovf", overflow, 1'b0);
        exp_dat = '{32'h13121110, 32'h17161514, 32'h23222120, 32'h27262524};
        exp_flg = '{3'b001, 3'b010, 3'b000, 3'b110};
        for (int k = 0; k < 4; k++) begin
            chk_head($sformatf("s3_w%0d", k), exp_flg[k], exp_dat[k]);
            cyc(1, 0, 0, 8'h00, 1);
        end
        check("s3_empty", bus.out_valid, 1'b0);

        // Overflow under backpressure, then DROP until the next frame
        cyc(0, 0, 0, 8'h00, 0);
        cyc(0, 0, 0, 8'h00, 0);
        vs_pulse(0);
        send_bytes(8'h40, 24, 0);
        cyc(1, 0, 0, 8'h00, 0);
        check("s4_ovf", overflow, 1'b1);
        check("s4_drop", drop_cnt, 16'd2);
        exp_dat = '{32'h43424140, 32'h47464544, 32'h4B4A4948, 32'h4F4E4D4C};
        exp_flg = '{3'b001, 3'b010, 3'b000, 3'b010};
        for (int k = 0; k < 4; k++) begin
            chk_head($sformatf("s4_w%0d", k), exp_flg[k], exp_dat[k]);
            cyc(1, 0, 0, 8'h00, 1);
        end
        send_bytes(8'h80, 8, 1);
        cyc(1, 0, 0, 8'h00, 1);
        check("s4_silent", bus.out_valid, 1'b0);
        check("s4_drop2", drop_cnt, 16'd4);
        vs_pulse(1);
        send_bytes(8'h90, 4, 1);
        chk_head("s4_resync", 3'b001, 32'h93929190);
        cyc(1, 0, 0, 8'h00, 1);

        // Push and pop together while full
        cyc(0, 0, 0, 8'h00, 0);
        vs_pulse(0);
        send_bytes(8'h60, 16, 0);
        send_bytes(8'h70, 3, 0);
        cyc(1, 0, 1, 8'h73, 1);
        check("s5_ovf", overflow, 1'b0);
        cyc(1, 0, 0, 8'h00, 0);
        exp_dat = '{32'h67666564, 32'h6B6A6968, 32'h6F6E6D6C, 32'h73727170};
        exp_flg = '{3'b010, 3'b000, 3'b010, 3'b000};
        for (int k = 0; k < 4; k++) begin
            chk_head($sformatf("s5_w%0d", k), exp_flg[k], exp_dat[k]);
            cyc(1, 0, 0, 8'h00, 1);
        end
        check("s5_empty", bus.out_valid, 1'b0);

        // vsync rising in the middle of a word
        send_bytes(8'h11, 2, 1);
        cyc(1, 1, 1, 8'h33, 1);
        cyc(1, 1, 1, 8'h44, 1);
        cyc(1, 1, 1, 8'h55, 1);
        cyc(1, 1, 1, 8'h66, 1);
        check("s6_none", bus.out_valid, 1'b0);
        cyc(1, 1, 1, 8'h77, 1);
        chk_head("s6_w0", 3'b001, 32'h77665544);
        cyc(1, 0, 0, 8'h00, 1);

        // Random traffic
        burst = 0; gap = 2; rv = 0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 59) == 0) rv = ~rv;
            if (burst > 0) begin
                rp = 1; burst--;
            end else if (gap > 0) begin
                rp = 0; gap--;
            end else begin
                rp = 0;
                burst = ($urandom_range(0, 1) == 1) ? PPL : int'($urandom_range(1, 14));
                gap = $urandom_range(1, 4);
            end
            rr   = ((c / 300) % 3 == 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            rrst = ($urandom_range(0, 1499) != 0);
            cyc(rrst, rv, rp, 8'($urandom), rr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
